// File: rtl/cmat_pingpong_buf.sv
// cmat_pingpong_buf: two-bank ROWS x COLS complex-matrix frame buffer.
// A frame is collected serially into one bank while the other bank drains,
// so reception of frame n+1 overlaps readout of frame n. Readout is
// row-major or transposed, selected per frame by mode_i on its first sample.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   valid_i/ready_o input handshake; R_i/I_i signed sample, mode_i order
//   abort_i         discard the partially filled write bank
//   valid_o/ready_i output handshake; R_o/I_o signed sample, last_o frame end
//   drop_o          registered pulse: a sample was offered while ready_o=0
module cmat_pingpong_buf #(
   parameter int ROWS    = 4,
   parameter int COLS    = 4,
   parameter int BIT_NUM = 18
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      valid_i,
   input  logic signed [BIT_NUM-1:0] R_i,
   input  logic signed [BIT_NUM-1:0] I_i,
   input  logic                      mode_i,
   input  logic                      abort_i,
   output logic                      ready_o,
   output logic                      valid_o,
   output logic signed [BIT_NUM-1:0] R_o,
   output logic signed [BIT_NUM-1:0] I_o,
   output logic                      last_o,
   input  logic                      ready_i,
   output logic                      drop_o
);
   localparam int N  = ROWS * COLS;
   localparam int AW = $clog2(N);
   localparam int RW = $clog2(ROWS);
   localparam int CW = $clog2(COLS);

   typedef enum logic [1:0] {EMPTY, FILLING, FULL} bank_st_t;

   logic signed [BIT_NUM-1:0] mem_r_q [2][N];
   logic signed [BIT_NUM-1:0] mem_i_q [2][N];
   bank_st_t                  bst_q [2];
   bank_st_t                  bst_d [2];
   logic                      tr_q [2];
   logic                      tr_d [2];
   logic                      wbank_q, wbank_d, rbank_q, rbank_d;
   logic [AW-1:0]             wcnt_q, wcnt_d;
   logic [RW-1:0]             rr_q, rr_d;
   logic [CW-1:0]             rc_q, rc_d;
   logic                      drop_q;
   logic                      acc, xfer;
   logic [AW-1:0]             rd_idx;

   assign ready_o = bst_q[wbank_q] != FULL;
   assign valid_o = bst_q[rbank_q] == FULL;
   assign acc     = valid_i & ready_o & ~abort_i;
   assign xfer    = valid_o & ready_i;
   // Element (r,c) sits at its arrival index r*COLS+c in either order.
   assign rd_idx  = AW'(rr_q) * AW'(COLS) + AW'(rc_q);
   // The final element is (ROWS-1,COLS-1) for both row-major and transposed.
   assign last_o  = valid_o & (rr_q == RW'(ROWS-1)) & (rc_q == CW'(COLS-1));
   assign R_o     = valid_o ? mem_r_q[rbank_q][rd_idx] : '0;
   assign I_o     = valid_o ? mem_i_q[rbank_q][rd_idx] : '0;
   assign drop_o  = drop_q;

   always_comb begin
      bst_d   = bst_q;
      tr_d    = tr_q;
      wbank_d = wbank_q;
      wcnt_d  = wcnt_q;
      rbank_d = rbank_q;
      rr_d    = rr_q;
      rc_d    = rc_q;
      // Abort only clears a FILLING bank; acc is already blocked by abort_i.
      if (abort_i && bst_q[wbank_q] == FILLING) begin
         bst_d[wbank_q] = EMPTY;
         wcnt_d         = '0;
      end else if (acc) begin
         if (wcnt_q == '0) begin
            tr_d[wbank_q]  = mode_i;
            bst_d[wbank_q] = FILLING;
         end
         if (wcnt_q == AW'(N-1)) begin
            bst_d[wbank_q] = FULL;
            wcnt_d         = '0;
            wbank_d        = ~wbank_q;
         end else begin
            wcnt_d = wcnt_q + AW'(1);
         end
      end
      // Read bank is FULL while write bank is not, so these never collide.
      if (xfer) begin
         if (last_o) begin
            bst_d[rbank_q] = EMPTY;
            rr_d           = '0;
            rc_d           = '0;
            rbank_d        = ~rbank_q;
         end else if (tr_q[rbank_q]) begin
            rr_d = (rr_q == RW'(ROWS-1)) ? '0 : rr_q + RW'(1);
            rc_d = (rr_q == RW'(ROWS-1)) ? rc_q + CW'(1) : rc_q;
         end else begin
            rc_d = (rc_q == CW'(COLS-1)) ? '0 : rc_q + CW'(1);
            rr_d = (rc_q == CW'(COLS-1)) ? rr_q + RW'(1) : rr_q;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int b = 0; b < 2; b++) begin
            bst_q[b] <= EMPTY;
            tr_q[b]  <= 1'b0;
         end
         wbank_q <= 1'b0;
         rbank_q <= 1'b0;
         wcnt_q  <= '0;
         rr_q    <= '0;
         rc_q    <= '0;
         drop_q  <= 1'b0;
      end else begin
         bst_q   <= bst_d;
         tr_q    <= tr_d;
         wbank_q <= wbank_d;
         rbank_q <= rbank_d;
         wcnt_q  <= wcnt_d;
         rr_q    <= rr_d;
         rc_q    <= rc_d;
         drop_q  <= valid_i & ~ready_o & ~abort_i;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int b = 0; b < 2; b++) begin
            for (int k = 0; k < N; k++) begin
               mem_r_q[b][k] <= '0;
               mem_i_q[b][k] <= '0;
            end
         end
      end else if (acc) begin
         mem_r_q[wbank_q][wcnt_q] <= R_i;
         mem_i_q[wbank_q][wcnt_q] <= I_i;
      end
   end
endmodule

// File: tb/tb_cmat_pingpong_buf.sv
// tb_cmat_pingpong_buf: scoreboard bench for cmat_pingpong_buf.
module tb_cmat_pingpong_buf;
   localparam int ROWS = 4;
   localparam int COLS = 4;
   localparam int BW   = 18;
   localparam int N    = ROWS * COLS;

   typedef struct packed {
      logic [BW-1:0] r;
      logic [BW-1:0] i;
      logic          last;
   } smp_t;

   logic          clk = 1'b0, rst_n = 1'b0;
   logic          valid_i = 1'b0, mode_i = 1'b0, abort_i = 1'b0, ready_i = 1'b0;
   logic [BW-1:0] r_i = '0, i_i = '0;
   logic          ready_o, valid_o, last_o, drop_o;
   logic [BW-1:0] r_o, i_o;

   smp_t          exp_q[$];
   logic [BW-1:0] fr[N];
   logic [BW-1:0] fi[N];
   int            fcnt = 0, pending = 0;
   logic          fmode = 1'b0, exp_drop = 1'b0;
   int            checks = 0, failures = 0;

   cmat_pingpong_buf #(.ROWS(ROWS), .COLS(COLS), .BIT_NUM(BW)) dut (
      .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .R_i(r_i), .I_i(i_i),
      .mode_i(mode_i), .abort_i(abort_i), .ready_o(ready_o), .valid_o(valid_o),
      .R_o(r_o), .I_o(i_o), .last_o(last_o), .ready_i(ready_i), .drop_o(drop_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
      end
   endtask

   // Reference model: a frame is a list of N samples; when complete it is
   // reordered as a whole and appended to the expected output queue.
   always @(negedge clk) begin
      logic acc, xfer;
      int   idx;
      if (!rst_n) begin
         chk("rst_valid", 64'(valid_o), 64'd0);
         chk("rst_ready", 64'(ready_o), 64'd1);
         chk("rst_drop", 64'(drop_o), 64'd0);
         chk("rst_data", 64'({r_o, i_o, last_o}), 64'd0);
         exp_q.delete();
         fcnt     = 0;
         pending  = 0;
         exp_drop = 1'b0;
      end else begin
         chk("ready", 64'(ready_o), 64'(pending < 2));
         chk("valid", 64'(valid_o), 64'(exp_q.size() > 0));
         chk("drop", 64'(drop_o), 64'(exp_drop));
         if (exp_q.size() > 0) begin
            chk("data_r", 64'(r_o), 64'(exp_q[0].r));
            chk("data_i", 64'(i_o), 64'(exp_q[0].i));
            chk("last", 64'(last_o), 64'(exp_q[0].last));
         end else begin
            chk("idle_out", 64'({r_o, i_o, last_o}), 64'd0);
         end
         acc      = valid_i && pending < 2 && !abort_i;
         xfer     = exp_q.size() > 0 && ready_i;
         exp_drop = valid_i && !(pending < 2) && !abort_i;
         if (xfer) begin
            if (exp_q[0].last) pending--;
            void'(exp_q.pop_front());
         end
         if (abort_i) begin
            fcnt = 0;
         end else if (acc) begin
            if (fcnt == 0) fmode = mode_i;
            fr[fcnt] = r_i;
            fi[fcnt] = i_i;
            fcnt++;
            if (fcnt == N) begin
               for (int j = 0; j < N; j++) begin
                  idx = fmode ? (j % ROWS) * COLS + j / ROWS : j;
                  exp_q.push_back('{r: fr[idx], i: fi[idx], last: (j == N-1)});
               end
               pending++;
               fcnt = 0;
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Only the first sample carries the wanted mode; the rest carry the
   // opposite to show the mode is latched once per frame.
   task automatic frame(input int base, input logic m);
      for (int k = 0; k < N; k++) begin
         valid_i = 1'b1;
         r_i     = BW'(base + k);
         i_i     = BW'(-(base + k));
         mode_i  = (k == 0) ? m : ~m;
         tick();
      end
      valid_i = 1'b0;
   endtask

   task automatic drain();
      ready_i = 1'b1;
      for (int t = 0; t < 100 && exp_q.size() > 0; t++) tick();
      tick();
      checks++;
      if (exp_q.size() > 0) begin
         failures++;
         $display("FAIL drain_timeout: %0d samples left, expected 0", exp_q.size());
      end
   endtask

   initial begin
      repeat (3) tick();
      rst_n = 1'b1;
      repeat (2) tick();
      ready_i = 1'b1;
      frame(0, 1'b0);
      drain();
      frame(0, 1'b1);
      drain();
      ready_i = 1'b0;
      frame(0, 1'b0);
      frame(16, 1'b1);
      frame(32, 1'b0);
      repeat (3) tick();
      drain();
      ready_i = 1'b0;
      frame(200, 1'b0);
      ready_i = 1'b1;
      repeat (5) tick();
      ready_i = 1'b0;
      repeat (3) tick();
      drain();
      for (int k = 0; k < 7; k++) begin
         valid_i = 1'b1;
         r_i     = BW'(50 + k);
         i_i     = BW'(k);
         tick();
      end
      abort_i = 1'b1;
      tick();
      abort_i = 1'b0;
      frame(100, 1'b0);
      drain();
      for (int c = 0; c < 1500; c++) begin
         valid_i = $urandom_range(0, 3) != 0;
         ready_i = $urandom_range(0, 3) != 0;
         abort_i = $urandom_range(0, 60) == 0;
         mode_i  = 1'($urandom);
         r_i     = BW'($urandom);
         i_i     = BW'($urandom);
         tick();
      end
      valid_i = 1'b0;
      abort_i = 1'b1;
      tick();
      abort_i = 1'b0;
      drain();
      ready_i = 1'b1;
      frame(300, 1'b1);
      repeat (4) tick();
      rst_n = 1'b0;
      repeat (2) tick();
      rst_n = 1'b1;
      repeat (6) tick();
      ready_i = 1'b1;
      frame(400, 1'b0);
      drain();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/cmat_pingpong_buf.md
# cmat_pingpong_buf

Parametrised ROWS x COLS complex-matrix frame buffer for the channel-processing front/back end. It collects serial complex samples into one of two banks and hands full matrices out serially, so reception of frame n+1 overlaps readout of frame n. Readout is row-major or transposed. Both sides use valid/ready handshakes with backpressure, and dropped input is flagged. It replaces the fixed 4x4 receive/send sequencing of the first-generation top level and feeds or drains the PE array schedule.

## Interface
- ROWS, default 4, matrix rows (>=2)
- COLS, default 4, matrix columns (>=2)
- BIT_NUM, default 18, signed width of each real/imag component
- clk  in  1  clock; one clock domain, rising edge
- rst_n  in  1  asynchronous, active-low reset
- valid_i  in  1  input sample valid
- R_i, I_i  in  BIT_NUM each  signed input sample, real/imag
- mode_i  in  1  readout order for the frame, sampled on the frame's first accepted sample (0 row-major, 1 transposed)
- abort_i  in  1  synchronous discard of the partially filled bank
- ready_o  out  1  input can accept this cycle
- valid_o  out  1  output sample valid
- R_o, I_o  out  BIT_NUM each  signed output sample
- last_o  out  1  marks the final sample of the frame on the output
- ready_i  in  1  downstream accepts this cycle
- drop_o  out  1  one-cycle pulse: a sample was offered while ready_o=0

## Operation
- N = ROWS*COLS. Address width is $clog2(N).
- Storage is two banks of N complex entries, held in registers. Each bank has state EMPTY, FILLING or FULL, plus a latched transpose flag.
- Write side:
  - Pointer wbank, counter wcnt.
  - ready_o = 1 iff bank[wbank] is not FULL. It is driven combinationally from registered state.
  - Accept = valid_i & ready_o & ~abort_i. On accept, the sample is written at address wcnt.
  - If wcnt==0, latch mode_i into the bank's transpose flag and set the bank to FILLING.
  - If wcnt==N-1, set the bank to FULL, set wcnt to 0 and toggle wbank. Otherwise wcnt+1.
- Read side:
  - Pointer rbank, row counter rr, column counter rc.
  - valid_o = bank[rbank] FULL.
  - Row-major: emit element (rr,rc) with rc inner. Transposed: rr inner.
  - Element (r,c) is stored at index r*COLS+c, which is its arrival order.
  - R_o/I_o are a combinational read of registered storage at the current element. They are 0 when valid_o=0.
  - last_o = valid_o & (current element is the final one in the active order).
  - Transfer = valid_o & ready_i. It advances the inner counter, carrying into the outer counter.
  - On the transfer with last_o: bank set to EMPTY, counters set to 0, rbank toggles.
- Simultaneous events:
  - Write completion and read completion on different banks in the same cycle are both applied.
  - When the write side fills the second bank while the first is still draining, ready_o falls until that bank empties and wbank points to an EMPTY bank.
- abort_i:
  - If bank[wbank] is FILLING, it becomes EMPTY and wcnt is set to 0.
  - FULL banks are untouched.
  - A sample offered in the abort cycle is discarded without a drop_o pulse.
- drop_o is a register set to valid_i & ~ready_o & ~abort_i.

## Timing
- Reset values: banks EMPTY, wbank=rbank=0, all counters 0, valid_o=0, last_o=0, R_o=I_o=0, drop_o=0, ready_o=1. Storage contents are cleared to 0.
- Reset mid-frame or mid-drain discards everything. There is no partial output after reset.
- Latency: if the final sample is accepted in cycle k and the read bank is idle, valid_o=1 and the first element appears in cycle k+1.
- Throughput: 1 sample/cycle in and out. Continuous streaming runs with no bubbles when ready_i=1.
- Output stability: while valid_o=1 and ready_i=0, R_o/I_o/last_o hold. No element is skipped or repeated.
- Full/empty:
  - When both banks are FULL, ready_o=0.
  - When both banks are EMPTY, valid_o=0.
  - The first bank to fill is the first drained (FIFO order of frames).
- Wrap: wbank and rbank toggle 0->1->0.
- Counters never exceed N-1, ROWS-1 or COLS-1 respectively.

## Test plan
- Reset: after rst_n release with no input -> ready_o=1, valid_o=0, drop_o=0, R_o=I_o=0.
- 4x4 row-major: 16 contiguous samples R=k, I=-k (k=0..15), mode_i=0, ready_i=1. Required response:
  - valid_o rises the cycle after the 16th accept.
  - Outputs are R=0..15 with I=-R.
  - last_o is asserted only with R=15.
- Transposed: same stimulus with mode_i=1 on sample 0 -> output R order 0,4,8,12,1,5,9,13,2,6,10,14,3,7,11,15.
- Ping-pong and backpressure: stream 3 frames with ready_i=0 throughout. Required response:
  - 32 samples are accepted.
  - ready_o drops after the 32nd accept.
  - Each further valid_i cycle gives a drop_o pulse one cycle later.
  - After ready_i=1, frame 0 then frame 1 are output intact.
  - ready_o rises the cycle after frame 0's last transfer.
- Mid-frame stall: ready_i=0 for 3 cycles during element 5 -> R_o=5 held for 3 cycles, then 6..15 follow.
- abort_i after 7 samples, then 16 new samples R=100+k -> output frame is exactly 100..115. Also apply rst_n low during drain -> valid_o=0 immediately and no stale data afterwards.
